// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the active-low request priority encoder.
package req_enc_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational pick of one pending index. Searches downward from start by default,
// upward from start when REQ_ENC_ROUND_ROBIN_EN is defined.
module prio_pick
  import req_enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0]            pending,
  input  logic [idx_width(N)-1:0] start,
  output logic [idx_width(N)-1:0] idx
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] w_cand;
  logic          w_found;

  // N is a power of two, so IW-bit arithmetic wraps modulo N for free
  always_comb begin
    idx     = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
`ifdef REQ_ENC_ROUND_ROBIN_EN
      w_cand = start + IW'(i);
`else
      w_cand = start - IW'(i);
`endif
      if (!w_found && pending[w_cand]) begin
        idx     = w_cand;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_prio_encoder.sv
// Captures falling edges on active-low request lines and grants one index at a time
// over a valid/ready handshake. Optional rotating priority: REQ_ENC_ROUND_ROBIN_EN.
module req_prio_encoder
  import req_enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_n,
  input  logic                    en_n,
  output logic [idx_width(N)-1:0] out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    any_n,
  output logic [N-1:0]            pend,
  output logic                    ovf
);

  localparam int IW = idx_width(N);

  state_e        r_state;
  logic [N-1:0]  r_pend;
  logic [N-1:0]  r_prev_n;
  logic [IW-1:0] r_idx;
  logic          r_valid;
  logic          r_ovf;

  logic [N-1:0]  w_fall;
  logic [N-1:0]  w_clr;
  logic          w_accept;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_pick;

  assign w_fall   = r_prev_n & ~req_n & {N{~en_n}};
  assign w_accept = (r_state == HOLD) && out_ready;

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_idx] = 1'b1;
  end

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [IW-1:0] r_last;

  always_ff @(posedge clk) begin
    if (rst) r_last <= IW'(N - 1);
    else if (w_accept) r_last <= r_idx;
  end

  assign w_start = r_last + IW'(1);
`else
  assign w_start = IW'(N - 1);
`endif

  prio_pick #(.N(N)) u_pick (
    .pending (r_pend),
    .start   (w_start),
    .idx     (w_pick)
  );

  // A set landing on the same edge as its clear wins, so a re-fall is not lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_prev_n <= '1;
      r_ovf    <= 1'b0;
    end else begin
      r_pend   <= (r_pend & ~w_clr) | w_fall;
      r_prev_n <= req_n;
      r_ovf    <= r_ovf | (|(w_fall & r_pend));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|r_pend) begin
            r_idx   <= w_pick;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign pend      = r_pend;
  assign ovf       = r_ovf;
  assign any_n     = ~|r_pend;

endmodule

// File: tb/tb_req_prio_encoder.sv
// Self-checking bench for req_prio_encoder (N=4); expected grants go through a scoreboard queue.
module tb_req_prio_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_n;
  logic       en_n;
  logic [1:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       any_n;
  logic [3:0] pend;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] sb_q[$];
  logic [1:0] exp_idx;

  req_prio_encoder #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_n     (req_n),
    .en_n      (en_n),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .any_n     (any_n),
    .pend      (pend),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_n = 4'b1111; en_n = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pop_grant(input string name);
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: grant idx=%0d seen, scoreboard empty", name, out_idx);
    end else begin
      exp_idx = sb_q.pop_front();
      if (out_idx !== exp_idx) begin
        n_err++;
        $display("FAIL %s: out_idx=%0d expected %0d", name, out_idx, exp_idx);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if ({out_valid, any_n, pend, ovf, out_idx} !== {1'b0, 1'b1, 4'b0000, 1'b0, 2'd0}) begin
        n_err++;
        $display("FAIL reset c%0d: valid=%b any_n=%b pend=%b ovf=%b idx=%0d expected 0 1 0000 0 0",
                 c, out_valid, any_n, pend, ovf, out_idx);
      end
    end
  endtask

  task automatic test_single();
    req_n = 4'b1011; en_n = 1'b0; out_ready = 1'b0;
    sb_q.push_back(2'd2);
    tick();
    n_cmp++;
    if (pend !== 4'b0100 || out_valid !== 1'b0 || any_n !== 1'b0) begin
      n_err++;
      $display("FAIL single_capture: pend=%b valid=%b any_n=%b expected 0100 0 0", pend, out_valid, any_n);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
        n_err++;
        $display("FAIL single_hold c%0d: valid=%b idx=%0d expected 1 2", c, out_valid, out_idx);
      end
      tick();
    end
    out_ready = 1'b1;
    if (out_valid) pop_grant("single_grant");
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || pend !== 4'b0000 || any_n !== 1'b1) begin
      n_err++;
      $display("FAIL single_accept: valid=%b pend=%b any_n=%b expected 0 0000 1", out_valid, pend, any_n);
    end
    req_n = 4'b1111;
    tick();
  endtask

  task automatic test_all_fall();
    int last_c;
    do_reset();
`ifdef REQ_ENC_ROUND_ROBIN_EN
    sb_q.push_back(2'd0); sb_q.push_back(2'd1); sb_q.push_back(2'd2); sb_q.push_back(2'd3);
`else
    sb_q.push_back(2'd3); sb_q.push_back(2'd2); sb_q.push_back(2'd1); sb_q.push_back(2'd0);
`endif
    req_n = 4'b0000; out_ready = 1'b1;
    tick();
    n_cmp++;
    if (pend !== 4'b1111 || any_n !== 1'b0) begin
      n_err++;
      $display("FAIL all_capture: pend=%b any_n=%b expected 1111 0", pend, any_n);
    end
    last_c = -1;
    for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
      tick();
      if (out_valid) begin
        pop_grant("all_order");
        if (last_c >= 0) begin
          n_cmp++;
          if (c - last_c !== 2) begin
            n_err++;
            $display("FAIL all_bubble: grant spacing=%0d expected 2", c - last_c);
          end
        end
        last_c = c;
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL all_timeout: %0d grants outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || pend !== 4'b0000 || ovf !== 1'b0 || any_n !== 1'b1) begin
        n_err++;
        $display("FAIL all_held_low c%0d: valid=%b pend=%b ovf=%b any_n=%b expected 0 0000 0 1",
                 c, out_valid, pend, ovf, any_n);
      end
    end
    req_n = 4'b1111; out_ready = 1'b0;
    tick();
  endtask

  task automatic test_disable();
    en_n = 1'b1; req_n = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (pend !== 4'b0000) begin
        n_err++;
        $display("FAIL disable_c%0d: pend=%b expected 0000", c, pend);
      end
    end
    en_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (pend !== 4'b0000 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reenable_c%0d: pend=%b valid=%b expected 0000 0", c, pend, out_valid);
      end
    end
    req_n = 4'b1111;
    tick();
  endtask

  task automatic test_refall();
    do_reset();
    sb_q.push_back(2'd3); sb_q.push_back(2'd3);
    req_n = 4'b0111;
    tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 2'd3 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL refall_grant: valid=%b idx=%0d ovf=%b expected 1 3 0", out_valid, out_idx, ovf);
    end
    req_n = 4'b1111;
    tick();
    req_n = 4'b0111; out_ready = 1'b1;
    if (out_valid) pop_grant("refall_first");
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1 || pend !== 4'b1000 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL refall_ovf: ovf=%b pend=%b valid=%b expected 1 1000 0", ovf, pend, out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL refall_regrant: valid=%b expected 1", out_valid);
    end
    out_ready = 1'b1;
    if (out_valid) pop_grant("refall_second");
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || pend !== 4'b0000 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL refall_done: valid=%b pend=%b ovf=%b expected 0 0000 1", out_valid, pend, ovf);
    end
    req_n = 4'b1111;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_n = 4'b0101;
    tick(); tick();
`ifdef REQ_ENC_ROUND_ROBIN_EN
    exp_idx = 2'd1;
`else
    exp_idx = 2'd3;
`endif
    n_cmp++;
    if (out_valid !== 1'b1 || pend !== 4'b1010 || out_idx !== exp_idx) begin
      n_err++;
      $display("FAIL midrst_pre: valid=%b pend=%b idx=%0d expected 1 1010 %0d", out_valid, pend, out_idx, exp_idx);
    end
    rst = 1'b1; req_n = 4'b1111;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, out_idx, pend, any_n, ovf} !== {1'b0, 2'd0, 4'b0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_post: valid=%b idx=%0d pend=%b any_n=%b ovf=%b expected 0 0 0000 1 0",
               out_valid, out_idx, pend, any_n, ovf);
    end
  endtask

  initial begin
    rst = 1'b1; req_n = 4'b1111; en_n = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_fall();
    test_disable();
    test_refall();
    test_reset_mid();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached expected completion");
    $fatal(1, "watchdog");
  end

endmodule
